// File: rtl/rr_pkt_arbiter.sv
// Round-robin, packet-locked arbiter with a single registered output stage.
// One channel is granted at a time; a grant taken on a non-last beat is held
// until that channel delivers its last beat. Data and index leave together
// from the output register so downstream muxing sees a consistent pair.
module rr_pkt_arbiter #(
    parameter  int NUM_OF_INPUTS = 5,
    parameter  int INPUT_WIDTH   = 4,
    localparam int SEL_W         = $clog2(NUM_OF_INPUTS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_OF_INPUTS-1:0] in_valid,
    input  logic [NUM_OF_INPUTS-1:0] in_last,
    input  logic [INPUT_WIDTH-1:0]   a [NUM_OF_INPUTS],
    output logic [NUM_OF_INPUTS-1:0] in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [INPUT_WIDTH-1:0]   f,
    output logic [SEL_W-1:0]         sel,
    output logic                     out_last
);

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } state_t;

    // Wrap constants sized to the index arithmetic so non-power-of-two
    // channel counts never produce an index past the last channel.
    localparam logic [SEL_W:0]   N_EXT    = (SEL_W+1)'(NUM_OF_INPUTS);
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_OF_INPUTS - 1);

    state_t                 state_reg, state_next;
    logic [SEL_W-1:0]       ptr_reg, ptr_next;
    logic [SEL_W-1:0]       owner_reg, owner_next;
    logic                   out_valid_reg, out_valid_next;
    logic [INPUT_WIDTH-1:0] f_reg, f_next;
    logic [SEL_W-1:0]       sel_reg, sel_next;
    logic                   last_reg, last_next;

    logic                   can_load;
    logic [SEL_W:0]         cand_sum [NUM_OF_INPUTS];
    logic [SEL_W-1:0]       cand_idx [NUM_OF_INPUTS];
    logic [NUM_OF_INPUTS-1:0] cand_hit;
    logic                   cand_found;
    logic [SEL_W-1:0]       cand_sel;

    logic                   grant_go;
    logic [SEL_W-1:0]       grant_idx;
    logic [INPUT_WIDTH-1:0] grant_data;
    logic                   grant_last;

    assign can_load = !out_valid_reg | out_ready;

    // Search order starts at the pointer: offset gi maps to channel
    // (ptr + gi) with an explicit subtract-on-overflow wrap.
    generate
        for (genvar gi = 0; gi < NUM_OF_INPUTS; gi++) begin : g_cand
            assign cand_sum[gi] = {1'b0, ptr_reg} + (SEL_W+1)'(gi);
            assign cand_idx[gi] = (cand_sum[gi] >= N_EXT) ?
                                  SEL_W'(cand_sum[gi] - N_EXT) :
                                  cand_sum[gi][SEL_W-1:0];
            assign cand_hit[gi] = in_valid[cand_idx[gi]];
        end
    endgenerate

    // Lowest search offset with a valid request wins.
    always_comb begin
        cand_found = 1'b0;
        cand_sel   = '0;
        for (int k = NUM_OF_INPUTS - 1; k >= 0; k--) begin
            if (cand_hit[k]) begin
                cand_found = 1'b1;
                cand_sel   = cand_idx[k];
            end
        end
    end

    // State register and output stage, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ARB;
            ptr_reg       <= '0;
            owner_reg     <= '0;
            out_valid_reg <= 1'b0;
            f_reg         <= '0;
            sel_reg       <= '0;
            last_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            ptr_reg       <= ptr_next;
            owner_reg     <= owner_next;
            out_valid_reg <= out_valid_next;
            f_reg         <= f_next;
            sel_reg       <= sel_next;
            last_reg      <= last_next;
        end
    end

    // Grant selection, handshake generation and next-state computation.
    always_comb begin
        state_next     = state_reg;
        ptr_next       = ptr_reg;
        owner_next     = owner_reg;
        out_valid_next = out_valid_reg;
        f_next         = f_reg;
        sel_next       = sel_reg;
        last_next      = last_reg;
        in_ready       = '0;
        grant_go       = 1'b0;
        grant_idx      = cand_sel;
        grant_data     = '0;
        grant_last     = 1'b0;

        case (state_reg)
            ARB: begin
                grant_idx = cand_sel;
                grant_go  = cand_found & can_load;
            end
            LOCK: begin
                // Only the owner may move; others wait even when valid.
                grant_idx = owner_reg;
                grant_go  = in_valid[owner_reg] & can_load;
            end
            default: begin
                grant_idx = cand_sel;
                grant_go  = 1'b0;
            end
        endcase

        for (int i = 0; i < NUM_OF_INPUTS; i++) begin
            if (grant_idx == SEL_W'(i)) begin
                in_ready[i] = grant_go;
                grant_data  = a[i];
                grant_last  = in_last[i];
            end
        end

        if (grant_go) begin
            out_valid_next = 1'b1;
            f_next         = grant_data;
            sel_next       = grant_idx;
            last_next      = grant_last;
            if (grant_last) begin
                ptr_next   = (grant_idx == LAST_IDX) ? '0 : grant_idx + SEL_W'(1);
                state_next = ARB;
            end else begin
                owner_next = grant_idx;
                state_next = LOCK;
            end
        end else if (out_ready) begin
            // Drain: payload registers keep their stale contents.
            out_valid_next = 1'b0;
        end
    end

    assign out_valid = out_valid_reg;
    assign f         = f_reg;
    assign sel       = sel_reg;
    assign out_last  = last_reg;

endmodule

// File: tb/tb_rr_pkt_arbiter.sv
// Testbench for rr_pkt_arbiter: directed scenarios plus randomized traffic,
// all checked against a cycle-level reference model of the arbitration rules.
module tb_rr_pkt_arbiter;

    localparam int N  = 5;
    localparam int W  = 4;
    localparam int SW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  in_valid, in_last, in_ready;
    logic [W-1:0]  a [N];
    logic          out_valid, out_ready, out_last;
    logic [W-1:0]  f;
    logic [SW-1:0] sel;

    // Reference model: pointer, lock owner (-1 when arbitrating), output stage.
    int            m_ptr, m_owner, m_sel, m_grant;
    bit            m_ov, m_last;
    logic [W-1:0]  m_f;
    logic [N-1:0]  exp_ready, obs_ready;
    int            n_checks = 0;
    int            n_pass   = 0;

    rr_pkt_arbiter #(.NUM_OF_INPUTS(N), .INPUT_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .a(a),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .f(f), .sel(sel), .out_last(out_last)
    );

    always #5 clk = ~clk;

    function automatic int model_pick();
        bit can_load = !m_ov || out_ready;
        if (!can_load) return -1;
        if (m_owner >= 0) return in_valid[m_owner] ? m_owner : -1;
        for (int k = 0; k < N; k++) begin
            int i = (m_ptr + k) % N;
            if (in_valid[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_owner = -1; m_ov = 0; m_f = '0; m_sel = 0; m_last = 0;
    endtask

    task automatic rand_inputs();
        in_valid  = N'($urandom);
        in_last   = N'($urandom);
        out_ready = ($urandom_range(0, 3) != 0);
        for (int i = 0; i < N; i++) a[i] = W'($urandom);
    endtask

    // Advance one clock: sample in_ready mid-cycle, update the model at the
    // edge, return 1 ns after the edge.
    task automatic cycle();
        @(negedge clk);
        obs_ready = in_ready;
        m_grant   = model_pick();
        exp_ready = '0;
        if (m_grant >= 0) exp_ready[m_grant] = 1'b1;
        @(posedge clk);
        if (m_grant >= 0) begin
            m_ov = 1; m_f = a[m_grant]; m_sel = m_grant; m_last = in_last[m_grant];
            if (in_last[m_grant]) begin
                m_ptr = (m_grant + 1) % N; m_owner = -1;
            end else begin
                m_owner = m_grant;
            end
        end else if (out_ready) begin
            m_ov = 0;
        end
        #1;
    endtask

    task automatic do_reset();
        #1 rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 20; c++) begin
            rand_inputs();
            cycle();
        end
        in_valid = '0;
        #1 rst = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if ({out_valid, f, sel, out_last} !== '0)
            $display("FAIL reset_async: got ov=%b f=%h sel=%0d last=%b want all 0", out_valid, f, sel, out_last);
        else n_pass++;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        out_ready = 1'b1;
        cycle();
        n_checks++;
        if (obs_ready !== '0 || out_valid !== 1'b0)
            $display("FAIL reset_idle: got ready=%b ov=%b want 00000 0", obs_ready, out_valid);
        else n_pass++;
        in_valid = 5'b10100; in_last = '1;
        cycle();
        n_checks++;
        if (obs_ready !== 5'b00100 || out_valid !== 1'b1 || sel !== SW'(2))
            $display("FAIL reset_first_grant: got ready=%b ov=%b sel=%0d want 00100 1 2", obs_ready, out_valid, sel);
        else n_pass++;
        $display("test_reset done");
    endtask

    task automatic test_fairness();
        int seq [7] = '{0, 1, 2, 3, 4, 0, 1};
        logic [W-1:0] drv;
        do_reset();
        in_valid = '1; in_last = '1; out_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            for (int i = 0; i < N; i++) a[i] = W'($urandom);
            drv = a[seq[c]];
            cycle();
            n_checks++;
            if (sel !== SW'(seq[c]) || f !== drv || out_valid !== 1'b1)
                $display("FAIL fair_seq[%0d]: got sel=%0d f=%h ov=%b want sel=%0d f=%h ov=1", c, sel, f, out_valid, seq[c], drv);
            else n_pass++;
            n_checks++;
            if (obs_ready !== exp_ready || {out_valid, f, sel, out_last} !== {m_ov, m_f, SW'(m_sel), m_last})
                $display("FAIL fair_model[%0d]: got ready=%b sel=%0d f=%h want ready=%b sel=%0d f=%h", c, obs_ready, sel, f, exp_ready, m_sel, m_f);
            else n_pass++;
        end
        $display("test_fairness done");
    endtask

    task automatic test_backpressure();
        logic [W-1:0]  held_f;
        logic [SW-1:0] held_sel;
        out_ready = 1'b1; in_valid = '1; in_last = '1;
        cycle();
        held_f = m_f; held_sel = SW'(m_sel);
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < N; i++) a[i] = W'($urandom);
            cycle();
            n_checks++;
            if (obs_ready !== '0 || out_valid !== 1'b1 || f !== held_f || sel !== held_sel)
                $display("FAIL bp_hold[%0d]: got ready=%b ov=%b f=%h sel=%0d want 00000 1 %h %0d", c, obs_ready, out_valid, f, sel, held_f, held_sel);
            else n_pass++;
        end
        out_ready = 1'b1;
        cycle();
        n_checks++;
        if (obs_ready !== exp_ready || obs_ready === '0 || {out_valid, f, sel, out_last} !== {m_ov, m_f, SW'(m_sel), m_last})
            $display("FAIL bp_release: got ready=%b sel=%0d f=%h want ready=%b sel=%0d f=%h", obs_ready, sel, f, exp_ready, m_sel, m_f);
        else n_pass++;
        $display("test_backpressure done");
    endtask

    task automatic test_packet_lock();
        logic [N-1:0] vld [5] = '{5'b00110, 5'b00110, 5'b00100, 5'b00110, 5'b00100};
        logic [N-1:0] lst [5] = '{5'b00100, 5'b00100, 5'b00100, 5'b00110, 5'b00100};
        logic [N-1:0] rdy [5] = '{5'b00010, 5'b00010, 5'b00000, 5'b00010, 5'b00100};
        do_reset();
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            in_valid = vld[c]; in_last = lst[c];
            for (int i = 0; i < N; i++) a[i] = W'($urandom);
            cycle();
            n_checks++;
            if (obs_ready !== rdy[c])
                $display("FAIL lock_ready[%0d]: got %b want %b", c, obs_ready, rdy[c]);
            else n_pass++;
            n_checks++;
            if ({out_valid, f, sel, out_last} !== {m_ov, m_f, SW'(m_sel), m_last})
                $display("FAIL lock_out[%0d]: got ov=%b sel=%0d f=%h want ov=%b sel=%0d f=%h", c, out_valid, sel, f, m_ov, m_sel, m_f);
            else n_pass++;
        end
        $display("test_packet_lock done");
    endtask

    task automatic test_sparse_wrap();
        int seq [3] = '{4, 0, 4};
        do_reset();
        out_ready = 1'b1; in_valid = 5'b01000; in_last = '1;
        cycle();
        in_valid = 5'b10001;
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < N; i++) a[i] = W'($urandom);
            cycle();
            n_checks++;
            if (sel !== SW'(seq[c]) || sel >= SW'(N) || {out_valid, f, sel, out_last} !== {m_ov, m_f, SW'(m_sel), m_last})
                $display("FAIL wrap[%0d]: got sel=%0d f=%h want sel=%0d f=%h", c, sel, f, seq[c], m_f);
            else n_pass++;
        end
        $display("test_sparse_wrap done");
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        out_ready = 1'b1; in_valid = 5'b01000; in_last = '0;
        cycle();
        cycle();
        do_reset();
        in_valid = 5'b01001; in_last = 5'b00001;
        cycle();
        n_checks++;
        if (obs_ready !== 5'b00001 || sel !== SW'(0) || out_valid !== 1'b1)
            $display("FAIL midrst_first: got ready=%b sel=%0d ov=%b want 00001 0 1", obs_ready, sel, out_valid);
        else n_pass++;
        cycle();
        n_checks++;
        if (obs_ready !== exp_ready || {out_valid, f, sel, out_last} !== {m_ov, m_f, SW'(m_sel), m_last})
            $display("FAIL midrst_next: got ready=%b sel=%0d want ready=%b sel=%0d", obs_ready, sel, exp_ready, m_sel);
        else n_pass++;
        $display("test_reset_mid_packet done");
    endtask

    task automatic test_random();
        int bad = 0;
        for (int c = 0; c < 400; c++) begin
            rand_inputs();
            cycle();
            n_checks++;
            if (obs_ready !== exp_ready || {out_valid, f, sel, out_last} !== {m_ov, m_f, SW'(m_sel), m_last}) begin
                bad++;
                $display("FAIL rand[%0d]: got ready=%b ov=%b f=%h sel=%0d last=%b want ready=%b ov=%b f=%h sel=%0d last=%b",
                         c, obs_ready, out_valid, f, sel, out_last, exp_ready, m_ov, m_f, m_sel, m_last);
            end else n_pass++;
        end
        $display("test_random done, %0d cycles with errors", bad);
    endtask

    initial begin
        rst = 1'b1; in_valid = '0; in_last = '0; out_ready = 1'b0;
        for (int i = 0; i < N; i++) a[i] = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_fairness();
        test_backpressure();
        test_packet_lock();
        test_sparse_wrap();
        test_reset_mid_packet();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
